// File: rtl/prbs_gen_chk.sv
`default_nettype none
// ============================================================================
// Module   : prbs_gen_chk
// Brief    : Selectable-order Fibonacci PRBS generator (W bits/cycle) and a
//            self-synchronising checker with lock detection and a saturating
//            bit-error counter. Define PRBS_ERR_INJECT_EN to add err_inject.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_gen_chk #(
    parameter int ORDER      = 9,
    parameter int W          = 1,
    parameter int SEED       = 1,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_en,
`ifdef PRBS_ERR_INJECT_EN
    input  logic             err_inject,
`endif
    output logic [W-1:0]     tx_data,
    output logic             tx_valid,
    input  logic [W-1:0]     rx_data,
    input  logic             rx_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    function automatic int tap_of(input int order);
        case (order)
            7:       tap_of = 1;
            9:       tap_of = 4;
            15:      tap_of = 1;
            23:      tap_of = 5;
            31:      tap_of = 3;
            default: tap_of = 1;
        endcase
    endfunction

    localparam int c_tap    = tap_of(ORDER);
    localparam int c_pc_w   = $clog2(W + 1);
    localparam int c_sum_w  = ERR_W + c_pc_w;
    localparam int c_bits_w = $clog2(ORDER + W + 1);
    localparam int c_good_w = $clog2(LOCK_CNT + 1);
    localparam int c_bad_w  = $clog2(UNLOCK_CNT + 1);

    localparam logic [ORDER-1:0] c_seed_raw = ORDER'(SEED);
    localparam logic [ORDER-1:0] c_seed     = (c_seed_raw == '0) ? '1 : c_seed_raw;
    localparam logic [ERR_W-1:0] c_err_max  = {ERR_W{1'b1}};

    localparam logic [0:0] c_hunt   = 1'b0;
    localparam logic [0:0] c_locked = 1'b1;

    generate
        if (!(ORDER == 7 || ORDER == 9 || ORDER == 15 || ORDER == 23 || ORDER == 31)
            || W < 1 || W > 32 || LOCK_CNT < 1 || UNLOCK_CNT < 1) begin : g_bad_param
            $error("prbs_gen_chk: illegal parameter set ORDER=%0d W=%0d", ORDER, W);
        end
    endgenerate

    // ------------------------------------------------------------------ generator
    logic [ORDER-1:0] r_gen;
    logic [ORDER-1:0] w_gen_next;
    logic [W-1:0]     w_gen_word;
    logic [W-1:0]     w_tx_word;
    logic [W-1:0]     r_tx_data;
    logic             r_tx_valid;

    always_comb begin
        w_gen_next = r_gen;
        w_gen_word = '0;
        for (int i = 0; i < W; i++) begin
            w_gen_word[i] = w_gen_next[0];
            w_gen_next    = {w_gen_next[0] ^ w_gen_next[c_tap], w_gen_next[ORDER-1:1]};
        end
    end

`ifdef PRBS_ERR_INJECT_EN
    // Only the emitted word is corrupted; the LFSR keeps the clean sequence.
    assign w_tx_word = w_gen_word ^ W'(err_inject);
`else
    assign w_tx_word = w_gen_word;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gen      <= c_seed;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= tx_en;
            if (tx_en) begin
                r_gen     <= w_gen_next;
                r_tx_data <= w_tx_word;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

    // -------------------------------------------------------------------- checker
    logic [ORDER-1:0]    r_chk;
    logic [ORDER-1:0]    w_chk_next;
    logic [W-1:0]        w_exp;
    logic [W-1:0]        w_mis;
    logic [c_pc_w-1:0]   w_pop;
    logic                w_err;
    logic [ERR_W-1:0]    w_err_base;
    logic [c_sum_w-1:0]  w_sum;
    logic [ERR_W-1:0]    w_err_sat;
    logic [0:0]          r_state;
    logic [c_bits_w-1:0] r_rx_bits;
    logic [c_good_w-1:0] r_good;
    logic [c_bad_w-1:0]  r_bad;
    logic [ERR_W-1:0]    r_err_cnt;

    // Checker state holds the last ORDER bits; the feedback bit predicts the next one.
    always_comb begin
        w_chk_next = r_chk;
        w_exp      = '0;
        for (int i = 0; i < W; i++) begin
            w_exp[i]   = w_chk_next[0] ^ w_chk_next[c_tap];
            w_chk_next = {(r_state == c_hunt) ? rx_data[i] : w_exp[i], w_chk_next[ORDER-1:1]};
        end
    end

    assign w_mis = rx_data ^ w_exp;
    assign w_err = |w_mis;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < W; i++) begin
            w_pop = w_pop + c_pc_w'(w_mis[i]);
        end
    end

    assign w_err_base = err_clr ? '0 : r_err_cnt;
    assign w_sum      = c_sum_w'(w_err_base) + c_sum_w'(w_pop);
    assign w_err_sat  = (w_sum > c_sum_w'(c_err_max)) ? c_err_max : w_sum[ERR_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chk     <= '0;
            r_state   <= c_hunt;
            r_rx_bits <= '0;
            r_good    <= '0;
            r_bad     <= '0;
            r_err_cnt <= '0;
        end else begin
            if (err_clr) begin
                r_err_cnt <= '0;
            end
            if (rx_valid) begin
                r_chk <= w_chk_next;
                if (r_state == c_hunt) begin
                    if (r_rx_bits < c_bits_w'(ORDER)) begin
                        r_rx_bits <= r_rx_bits + c_bits_w'(W);
                    end else if (w_err) begin
                        r_good <= '0;
                    end else if (r_good == c_good_w'(LOCK_CNT - 1)) begin
                        r_state <= c_locked;
                        r_good  <= '0;
                    end else begin
                        r_good <= r_good + 1'b1;
                    end
                end else begin
                    r_err_cnt <= w_err_sat;
                    if (!w_err) begin
                        r_bad <= '0;
                    end else if (r_bad == c_bad_w'(UNLOCK_CNT - 1)) begin
                        r_state   <= c_hunt;
                        r_bad     <= '0;
                        r_rx_bits <= '0;
                    end else begin
                        r_bad <= r_bad + 1'b1;
                    end
                end
            end
        end
    end

    assign locked  = (r_state == c_locked);
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs_gen_chk.sv
`default_nettype none
// Testbench for prbs_gen_chk: four parameterisations (O9/W1, O7/W1 zero seed,
// O15/W8 loopback, O15/W8 with 4-bit error counter) checked against directed values.
module tb_prbs_gen_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       tx_en;
    logic       err_clr;
    logic       err_inject;
    logic [7:0] flip_c;
    logic [7:0] flip_d;
    int         total = 0;
    int         bad   = 0;

    logic        a_tx, a_txv, a_locked;
    logic [15:0] a_err;
    logic        b_tx, b_txv, b_locked;
    logic [15:0] b_err;
    logic [7:0]  c_tx, c_rx;
    logic        c_txv, c_locked;
    logic [15:0] c_err;
    logic [7:0]  d_tx, d_rx;
    logic        d_txv, d_locked;
    logic [3:0]  d_err;

    assign c_rx = c_tx ^ flip_c;
    assign d_rx = d_tx ^ flip_d;

    prbs_gen_chk #(.ORDER(9), .W(1), .SEED(1), .LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(16)) dut_a (
        .clk(clk), .reset(reset), .tx_en(tx_en),
`ifdef PRBS_ERR_INJECT_EN
        .err_inject(1'b0),
`endif
        .tx_data(a_tx), .tx_valid(a_txv), .rx_data(1'b0), .rx_valid(1'b0),
        .err_clr(1'b0), .locked(a_locked), .err_cnt(a_err));

    prbs_gen_chk #(.ORDER(7), .W(1), .SEED(0), .LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(16)) dut_b (
        .clk(clk), .reset(reset), .tx_en(tx_en),
`ifdef PRBS_ERR_INJECT_EN
        .err_inject(1'b0),
`endif
        .tx_data(b_tx), .tx_valid(b_txv), .rx_data(1'b0), .rx_valid(1'b0),
        .err_clr(1'b0), .locked(b_locked), .err_cnt(b_err));

    prbs_gen_chk #(.ORDER(15), .W(8), .SEED(1), .LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(16)) dut_c (
        .clk(clk), .reset(reset), .tx_en(tx_en),
`ifdef PRBS_ERR_INJECT_EN
        .err_inject(err_inject),
`endif
        .tx_data(c_tx), .tx_valid(c_txv), .rx_data(c_rx), .rx_valid(c_txv),
        .err_clr(1'b0), .locked(c_locked), .err_cnt(c_err));

    prbs_gen_chk #(.ORDER(15), .W(8), .SEED(1), .LOCK_CNT(4), .UNLOCK_CNT(4), .ERR_W(4)) dut_d (
        .clk(clk), .reset(reset), .tx_en(tx_en),
`ifdef PRBS_ERR_INJECT_EN
        .err_inject(1'b0),
`endif
        .tx_data(d_tx), .tx_valid(d_txv), .rx_data(d_rx), .rx_valid(d_txv),
        .err_clr(err_clr), .locked(d_locked), .err_cnt(d_err));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_en = 1'b0; err_clr = 1'b0; err_inject = 1'b0;
        flip_c = '0; flip_d = '0;
        tick(); tick();
        total++; if (a_txv !== 1'b0) begin bad++; $display("FAIL rst_txv: got %b want 0", a_txv); end
        total++; if (c_tx !== 8'h00) begin bad++; $display("FAIL rst_txdata: got %h want 00", c_tx); end
        total++; if (c_locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", c_locked); end
        total++; if (c_err !== 16'd0) begin bad++; $display("FAIL rst_errcnt: got %0d want 0", c_err); end
        total++; if (dut_a.r_gen !== 9'h001) begin bad++; $display("FAIL rst_seed: got %h want 001", dut_a.r_gen); end
        reset = 1'b0;
    endtask

    task automatic test_seed_zero();
        logic [6:0] m;
        logic       exp_bit;
        int         errs, zeros;
        logic       first;
        pulse_reset();
        total++; if (dut_b.r_gen !== 7'h7F) begin bad++; $display("FAIL seed0_state: got %h want 7f", dut_b.r_gen); end
        m = 7'h7F; errs = 0; zeros = 0; first = 1'b0;
        tx_en = 1'b1;
        for (int k = 0; k < 254; k++) begin
            tick();
            exp_bit = m[0];
            m = {m[0] ^ m[1], m[6:1]};
            if (k == 0) first = b_tx;
            if (b_tx !== exp_bit) errs++;
            if (dut_b.r_gen == 7'h00) zeros++;
            if (k == 126) begin
                total++; if (dut_b.r_gen !== 7'h7F) begin bad++; $display("FAIL seed0_period: got %h want 7f", dut_b.r_gen); end
            end
        end
        tx_en = 1'b0;
        total++; if (first !== 1'b1) begin bad++; $display("FAIL seed0_first: got %b want 1", first); end
        total++; if (errs != 0) begin bad++; $display("FAIL seed0_seq: got %0d bit errors want 0", errs); end
        total++; if (zeros != 0) begin bad++; $display("FAIL seed0_lockup: got %0d zero states want 0", zeros); end
    endtask

    task automatic test_gen_seq();
        logic [8:0]   m;
        logic         exp_bit;
        logic [9:0]   head;
        logic [510:0] per;
        int           errs, rep_errs, ones;
        pulse_reset();
        m = 9'h001; errs = 0; rep_errs = 0; ones = 0; head = '0;
        tx_en = 1'b1;
        for (int k = 0; k < 1022; k++) begin
            tick();
            exp_bit = m[0];
            m = {m[0] ^ m[4], m[8:1]};
            if (a_tx !== exp_bit || a_txv !== 1'b1) errs++;
            if (k < 10) head[k] = a_tx;
            if (k < 511) begin
                per[k] = a_tx;
                if (a_tx) ones++;
            end else if (a_tx !== per[k-511]) begin
                rep_errs++;
            end
        end
        total++; if (head !== 10'b10_0000_0001) begin bad++; $display("FAIL o9_head: got %b want 1000000001", head); end
        total++; if (errs != 0) begin bad++; $display("FAIL o9_seq: got %0d bit errors want 0", errs); end
        total++; if (rep_errs != 0) begin bad++; $display("FAIL o9_period: got %0d repeat errors want 0", rep_errs); end
        total++; if (ones != 256) begin bad++; $display("FAIL o9_ones: got %0d want 256", ones); end
        // Generator must freeze while tx_en is low.
        tx_en = 1'b0;
        tick(); tick();
        total++; if (a_txv !== 1'b0) begin bad++; $display("FAIL hold_valid: got %b want 0", a_txv); end
        total++; if (a_tx !== exp_bit) begin bad++; $display("FAIL hold_data: got %b want %b", a_tx, exp_bit); end
        tx_en = 1'b1;
        tick();
        total++; if (a_tx !== m[0]) begin bad++; $display("FAIL resume_data: got %b want %b", a_tx, m[0]); end
    endtask

    task automatic test_lock();
        int n;
        pulse_reset();
        flip_c = '0; flip_d = '0; tx_en = 1'b1;
        for (n = 1; n <= 50; n++) begin
            tick();
            if (c_locked) break;
        end
        total++; if (n != 7) begin bad++; $display("FAIL lock_latency: got %0d cycles want 7", n); end
        total++; if (d_locked !== 1'b1) begin bad++; $display("FAIL lock_d: got %b want 1", d_locked); end
    endtask

    task automatic test_clean_run();
        int unlocked, dirty;
        unlocked = 0; dirty = 0;
        for (int k = 0; k < 10000; k++) begin
            tick();
            if (!c_locked) unlocked++;
            if (c_err != 0 || d_err != 0) dirty++;
        end
        total++; if (unlocked != 0) begin bad++; $display("FAIL clean_locked: got %0d unlocked cycles want 0", unlocked); end
        total++; if (dirty != 0) begin bad++; $display("FAIL clean_err: got %0d errored cycles want 0", dirty); end
    endtask

    task automatic test_bit_errors();
        int n;
        for (int j = 0; j < 3; j++) begin
            flip_c = 8'h01 << (j * 3);
            tick();
            flip_c = '0;
            tick(); tick();
        end
        total++; if (c_err !== 16'd3) begin bad++; $display("FAIL single_err: got %0d want 3", c_err); end
        total++; if (c_locked !== 1'b1) begin bad++; $display("FAIL single_lock: got %b want 1", c_locked); end
        flip_c = 8'hFF;
        tick(); tick(); tick();
        total++; if (c_locked !== 1'b1 || c_err !== 16'd27) begin
            bad++; $display("FAIL inv3: got locked=%b err=%0d want 1/27", c_locked, c_err);
        end
        tick();
        flip_c = '0;
        total++; if (c_err !== 16'd35) begin bad++; $display("FAIL inv4_err: got %0d want 35", c_err); end
        total++; if (c_locked !== 1'b0) begin bad++; $display("FAIL inv4_unlock: got %b want 0", c_locked); end
        for (n = 1; n <= 50; n++) begin
            tick();
            if (c_locked) break;
        end
        total++; if (n != 6) begin bad++; $display("FAIL relock: got %0d cycles want 6", n); end
        total++; if (c_err !== 16'd35) begin bad++; $display("FAIL hunt_err: got %0d want 35", c_err); end
    endtask

    task automatic test_idle();
        tx_en = 1'b0;
        tick();
        flip_c = 8'hFF;
        repeat (4) tick();
        flip_c = '0;
        tx_en = 1'b1;
        repeat (6) tick();
        total++; if (c_err !== 16'd35 || c_locked !== 1'b1) begin
            bad++; $display("FAIL idle: got locked=%b err=%0d want 1/35", c_locked, c_err);
        end
    endtask

    task automatic test_saturation();
        for (int j = 0; j < 14; j++) begin
            flip_d = 8'h02; tick();
            flip_d = '0;    tick();
        end
        total++; if (d_err !== 4'd14) begin bad++; $display("FAIL sat_14: got %0d want 14", d_err); end
        flip_d = 8'h07; tick();
        flip_d = '0;    tick();
        total++; if (d_err !== 4'd15) begin bad++; $display("FAIL sat_edge: got %0d want 15", d_err); end
        for (int j = 0; j < 6; j++) begin
            flip_d = 8'h40; tick();
            flip_d = '0;    tick();
        end
        total++; if (d_err !== 4'd15 || d_locked !== 1'b1) begin
            bad++; $display("FAIL sat_hold: got err=%0d locked=%b want 15/1", d_err, d_locked);
        end
        err_clr = 1'b1; tick();
        total++; if (d_err !== 4'd0) begin bad++; $display("FAIL clr_clean: got %0d want 0", d_err); end
        flip_d = 8'h81; tick();
        err_clr = 1'b0; flip_d = '0;
        total++; if (d_err !== 4'd2) begin bad++; $display("FAIL clr_add: got %0d want 2", d_err); end
        tick();
        total++; if (d_err !== 4'd2) begin bad++; $display("FAIL clr_after: got %0d want 2", d_err); end
    endtask

`ifdef PRBS_ERR_INJECT_EN
    task automatic test_err_inject();
        err_inject = 1'b1; tick();
        err_inject = 1'b0; tick();
        total++; if (c_err !== 16'd36) begin bad++; $display("FAIL inject_err: got %0d want 36", c_err); end
        repeat (5) tick();
        total++; if (c_err !== 16'd36 || c_locked !== 1'b1) begin
            bad++; $display("FAIL inject_clean: got err=%0d locked=%b want 36/1", c_err, c_locked);
        end
    endtask
`endif

    task automatic test_reset_midstream();
        tick();
        #3 reset = 1'b1;
        #1;
        total++; if (c_locked !== 1'b0 || c_err !== 16'd0) begin
            bad++; $display("FAIL async_rst_chk: got locked=%b err=%0d want 0/0", c_locked, c_err);
        end
        total++; if (c_txv !== 1'b0 || c_tx !== 8'h00) begin
            bad++; $display("FAIL async_rst_gen: got valid=%b data=%h want 0/00", c_txv, c_tx);
        end
        tick();
        reset = 1'b0;
        tx_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seed_zero();
        test_gen_seq();
        test_lock();
        test_clean_run();
        test_bit_errors();
        test_idle();
        test_saturation();
`ifdef PRBS_ERR_INJECT_EN
        test_err_inject();
`endif
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
